// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise, deglitch, frame, decode E0/F0 prefixes into a toggle-strobed key word.
// Optional PS2_REPEAT_FILTER_EN suppresses typematic repeats of the currently held key.
module ps2_key_rx #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  // state  | meaning
  // IDLE   | waiting for a start bit on a falling edge
  // DATA   | shifting in the 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | next edge carries the stop bit; frame is judged there
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT - 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [1:0]      clk_sync, dat_sync;
  logic            clk_f, dat_f, clk_f_d;
  logic [FW-1:0]   clk_cnt, dat_cnt;
  logic [TW-1:0]   tmr;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            par, ext, rel;
  logic            fall, stop_hit, frame_ok, suppress, held_match;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      clk_cnt  <= '0;
      dat_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_f_d  <= clk_f;
      // level only moves after FILT consecutive samples disagreeing with it
      if (clk_sync[1] == clk_f) clk_cnt <= '0;
      else if (clk_cnt == FLAST) begin
        clk_f   <= clk_sync[1];
        clk_cnt <= '0;
      end else clk_cnt <= clk_cnt + 1'b1;
      if (dat_sync[1] == dat_f) dat_cnt <= '0;
      else if (dat_cnt == FLAST) begin
        dat_f   <= dat_sync[1];
        dat_cnt <= '0;
      end else dat_cnt <= dat_cnt + 1'b1;
    end
  end

  assign fall     = clk_f_d & ~clk_f;
  assign frame_ok = dat_f & (^{shreg, par});

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stop_hit = 1'b0;
    case (state)
      IDLE:   if (fall && !dat_f) state_nx = DATA;
      DATA:   if (fall && bitcnt == 3'd7) state_nx = PARITY;
      PARITY: if (fall) state_nx = STOP;
      STOP:   if (fall) begin
                state_nx = IDLE;
                stop_hit = 1'b1;
              end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && tmr == '0 && !fall) state_nx = IDLE;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) tmr <= '0;
    else if (state == IDLE || fall) tmr <= TLOAD;
    else if (tmr != '0) tmr <= tmr - 1'b1;
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       held_valid, held_ext;
  logic [7:0] held_code;
  assign held_match = held_valid && (held_ext == ext) && (held_code == shreg);
  assign suppress   = !rel && held_match;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (stop_hit && frame_ok && shreg != 8'hE0 && shreg != 8'hF0) begin
      if (!rel && !held_match) begin
        held_valid <= 1'b1;
        held_ext   <= ext;
        held_code  <= shreg;
      end else if (rel && held_match) held_valid <= 1'b0;
    end
  end
`else
  assign held_match = 1'b0;
  assign suppress   = held_match;
`endif

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      ps2_key   <= '0;
      frame_err <= 1'b0;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      rel       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {dat_f, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY: par <= dat_f;
          default: ;
        endcase
      end
      if (stop_hit) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          ext       <= 1'b0;
          rel       <= 1'b0;
        end else if (shreg == 8'hE0) ext <= 1'b1;
        else if (shreg == 8'hF0) rel <= 1'b1;
        else begin
          if (!suppress) ps2_key <= {~ps2_key[10], ~rel, ext, shreg};
          ext <= 1'b0;
          rel <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed plus randomized frames against a prefix/event-level model of the PS/2 key receiver.
module tb_ps2_key_rx;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_fail = 0, cyc = 0, stop_cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // observed activity
  int tog_cnt = 0, err_cnt = 0, wide_err = 0, unstable = 0, last_chg = 0;
  logic prev_tog = 1'b0, prev_err = 1'b0;
  logic [9:0] prev_low = '0;
  always @(negedge clk_sys) begin
    if (RESET) begin
      prev_tog = 1'b0; prev_low = '0; prev_err = 1'b0;
    end else begin
      if (ps2_key[10] !== prev_tog) begin tog_cnt++; last_chg = cyc; end
      else if (ps2_key[9:0] !== prev_low) unstable++;
      if (frame_err) begin err_cnt++; if (prev_err) wide_err++; end
      prev_tog = ps2_key[10]; prev_low = ps2_key[9:0]; prev_err = frame_err;
    end
  end

  // reference model: per-frame rules on bytes
  logic [10:0] m_key;
  logic m_ext, m_rel, h_valid, h_ext;
  logic [7:0] h_code;
  int m_tog, m_err;

  task automatic model_reset();
    m_key = '0; m_ext = 0; m_rel = 0; h_valid = 0; h_ext = 0; h_code = '0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    bit emit, match;
    if (!good) begin m_err++; m_ext = 0; m_rel = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      emit = 1;
`ifdef PS2_REPEAT_FILTER_EN
      match = h_valid && h_ext == m_ext && h_code == b;
      if (!m_rel && match) emit = 0;
      else if (!m_rel) begin h_valid = 1; h_ext = m_ext; h_code = b; end
      else if (match) h_valid = 0;
`else
      match = 0;
      if (match) emit = 0;
`endif
      if (emit) begin m_key = {~m_key[10], ~m_rel, m_ext, b}; m_tog++; end
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key"}, 32'(ps2_key), 32'(m_key));
    check({tag, "_tog"}, tog_cnt, m_tog);
    check({tag, "_err"}, err_cnt, m_err);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // one PS/2 bit: data set while clock high, then clock low; optional short low glitch in the high phase
  task automatic ps2_bit(input logic b, input bit glitch, input bit is_stop);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(4); ps2_clk = 0; wait_cyc(FILT - 2); ps2_clk = 1; wait_cyc(HALF - 4 - (FILT - 2));
    end else wait_cyc(HALF);
    if (is_stop) stop_cyc = cyc;
    ps2_clk = 0; wait_cyc(HALF); ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_bit);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_bit, i == 10);
    ps2_data = 1; wait_cyc(2 * HALF);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(bits[i], 0, 0);
    ps2_data = 1;
  endtask

  initial begin
    int d, t0;
    logic [10:0] saved;
    logic [7:0] rb;
    int r;
    model_reset(); m_tog = 0; m_err = 0;
    wait_cyc(5);
    check("rst_key", 32'(ps2_key), 0);
    check("rst_err", 32'(frame_err), 0);
    RESET = 0; wait_cyc(5);

    send_frame(8'h1C, 0, 0, -1);
    check("f1c_key", 32'(ps2_key), 32'h61C);
    d = last_chg - stop_cyc;
    check("f1c_latency", 32'(d >= FILT + 2 && d <= FILT + 4), 1);
    check_state("f1c");

    t0 = tog_cnt;
    send_frame(8'hE0, 0, 0, -1); send_frame(8'h75, 0, 0, -1);
    check("e075_low", 32'(ps2_key[9:0]), 32'h375);
    check("e075_ntog", tog_cnt - t0, 1);
    send_frame(8'hE0, 0, 0, -1); send_frame(8'hF0, 0, 0, -1); send_frame(8'h75, 0, 0, -1);
    check("e0f075_low", 32'(ps2_key[9:0]), 32'h175);
    check("e0f075_ntog", tog_cnt - t0, 2);
    check_state("ext");

    saved = ps2_key; t0 = err_cnt;
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h29, 1, 0, -1);
    check("badpar_key", 32'(ps2_key), 32'(saved));
    check("badpar_err", err_cnt - t0, 1);
    send_frame(8'hF0, 0, 0, -1); send_frame(8'h29, 0, 0, -1);
    check("f029_low", 32'(ps2_key[9:0]), 32'h029);
    send_frame(8'h33, 0, 1, -1);
    check_state("badstop");

    t0 = tog_cnt;
    send_partial(8'h16, 5);
    wait_cyc(TIMEOUT + 10);
    send_frame(8'h16, 0, 0, -1);
    check("tmo_ntog", tog_cnt - t0, 1);
    check("tmo_low", 32'(ps2_key[9:0]), 32'h216);
    check_state("tmo");

    send_frame(8'h3A, 0, 0, 4);
    check("glitch_low", 32'(ps2_key[9:0]), 32'h23A);
    check_state("glitch");

    send_frame(8'hF0, 0, 0, -1); send_frame(8'hE0, 0, 0, -1); send_frame(8'h6B, 0, 0, -1);
    check("f0e0_low", 32'(ps2_key[9:0]), 32'h16B);

    send_partial(8'h55, 4);
    @(negedge clk_sys); RESET = 1; #1;
    check("midrst_key", 32'(ps2_key), 0);
    model_reset();
    wait_cyc(3); RESET = 0; wait_cyc(3);
    send_frame(8'h1C, 0, 0, -1);
    check_state("postrst");

    RESET = 1; wait_cyc(2); RESET = 0; model_reset(); wait_cyc(2);
    t0 = tog_cnt;
    send_frame(8'h1C, 0, 0, -1); send_frame(8'h1C, 0, 0, -1); send_frame(8'h1C, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1); send_frame(8'h1C, 0, 0, -1); send_frame(8'h1C, 0, 0, -1);
`ifdef PS2_REPEAT_FILTER_EN
    check("rpt_ntog", tog_cnt - t0, 3);
`else
    check("rpt_ntog", tog_cnt - t0, 5);
`endif
    check_state("rpt");

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (r < 2) rb = 8'hE0;
      else if (r < 4) rb = 8'hF0;
      else if (r < 6) rb = 8'h1C;
      if ($urandom_range(0, 7) == 0) send_frame(rb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
      else send_frame(rb, 0, 0, -1);
      check_state("rand");
    end

    check("err_width", wide_err, 0);
    check("low_stable", unstable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
